generator_seq: RTL and testbench
================================

Name: generator_seq

Overview:
- Time-multiplexed, fully parametrised successor of the fixed 2-3-9 generator network.
- Evaluates a two-layer MLP (N_IN inputs -> N_HID hidden -> N_OUT outputs) with one shared signed fixed-point MAC, one product per clock.
- Valid/ready handshake on input vector and output vector.
- Sits between the latent-vector source and the image sink; weights/biases come from parameter registers on flat buses.

Parameters:
- WIDTH, 32, datapath word width (signed two's complement).
- FRAC, 16, fractional bits of the Q format (1.0 = 1<<FRAC).
- N_IN, 2, input vector length.
- N_HID, 3, hidden-layer neuron count.
- N_OUT, 9, output-layer neuron count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept an input vector.
- x  in  N_IN*WIDTH  input vector; element k at [(k+1)*WIDTH-1 : k*WIDTH].
- w_L2  in  N_IN*N_HID*WIDTH  hidden weights; neuron i, input k at slice index N_IN*i+k.
- b_L2  in  N_HID*WIDTH  hidden biases; slice i.
- w_L3  in  N_HID*N_OUT*WIDTH  output weights; neuron j, hidden input i at slice index N_HID*j+i.
- b_L3  in  N_OUT*WIDTH  output biases; slice j.
- out_valid  out  1  y holds a complete result.
- out_ready  in  1  sink accepts y.
- y  out  N_OUT*WIDTH  output vector; slice j. For a 3x3 image, j = 3*row + col.

Behaviour:
- Reset (async, immediate): state IDLE, in_ready=1, out_valid=0, y=0, accumulator, counters and hidden registers cleared. Any transaction in flight is discarded; nothing is accepted while rst=1.
- States: IDLE, L2, L3, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at an edge:
  - register x;
  - acc <= b_L2[0]; counters clear;
  - go to L2; in_ready=0 from next cycle.
- L2: each edge computes acc_next = acc + ((x[k]*w_L2[i][k]) >>> FRAC).
  - Product is the full 2*WIDTH signed product, arithmetic shift, truncated to WIDTH.
  - Accumulator wraps at WIDTH.
  - When k=N_IN-1: h[i] <= ReLU(acc_next) (negative -> 0); acc <= next bias (b_L2[i+1], or b_L3[0] after the last hidden neuron).
  - After neuron N_HID-1, go to L3.
- L3: same MAC using h[i] and w_L3[j][i].
  - When i=N_HID-1: y[j] <= clamp(acc_next, -1.0, +1.0) (hard tanh: -(1<<FRAC) .. (1<<FRAC)); acc <= b_L3[j+1].
  - After neuron N_OUT-1: out_valid <= 1, go to DONE.
- Latency: out_valid rises exactly N_IN*N_HID + N_HID*N_OUT edges after the accepting edge (33 with defaults).
- DONE:
  - out_valid=1; y stable.
  - On out_ready at an edge: out_valid <= 0, go to IDLE, in_ready=1 next cycle.
  - No new input is accepted in the same cycle as output release.
- y slices update only in L3, one slice per completed output neuron; y is valid only while out_valid=1.
- Weights/biases are sampled live each MAC cycle; the source must hold them stable from accept to out_valid.
- in_valid while busy is ignored; the upstream must hold it until in_ready.
- out_ready while not in DONE has no effect.

Optional Feature:
- GENERATOR_SAT_EN.
  - Defined: shifted product and accumulator sum saturate to [-(2^(WIDTH-1)), 2^(WIDTH-1)-1] instead of wrapping.
  - Undefined: plain two's-complement truncation/wrap as above.
  - Latency and handshake identical either way.

Test Plan:
- Defaults, FRAC=16; w_L2=w_L3=0, b_L3 all 0x00008000 -> every y slice = 0x00008000; out_valid rises exactly 33 cycles after the accepting edge.
- x=(0x00010000, 0x00010000), w_L2 all 0x00010000, b_L2=0 (h=2.0); w_L3 all 0x00004000, b_L3=0 -> each sum 1.5, y all 0x00010000. Same with w_L3 all 0xFFFFC000 -> y all 0xFFFF0000.
- w_L2 all 0xFFFF0000, x=(1.0, 1.0), b_L2=0 -> h clipped to 0 by ReLU; y[j] = b_L3[j] for b_L3[j]=j*0x1000.
- Hold out_ready=0 for 10 cycles after out_valid while pulsing in_valid -> y and out_valid stable, in_ready=0, no second accept. Raise out_ready -> out_valid=0 next cycle, in_ready=1 next cycle.
- Assert rst for 1 cycle during L3 (cycle 20) -> out_valid=0, y=0, in_ready=1 immediately. A following transaction from the second scenario yields the correct result after 33 cycles.
- x=(0x40000000, 0x40000000), w_L2 all 0x00040000, b_L2=0; w_L3[0]=(0x00010000, 0, 0), b_L3=0:
  - with GENERATOR_SAT_EN, y[0]=0x00010000;
  - without it, products wrap to 0, so y[0]=0x00000000.

Source files
------------

// File: rtl/generator_if.sv
// Handshake bundle between the latent-vector source, the generator and the
// image sink. The generator uses the slave view; the source/sink side uses master.
interface generator_if #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 2,
  parameter int N_OUT = 9
);
  logic                   in_valid;
  logic                   in_ready;
  logic [N_IN*WIDTH-1:0]  x;
  logic                   out_valid;
  logic                   out_ready;
  logic [N_OUT*WIDTH-1:0] y;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/generator_seq.sv
// Time-multiplexed two-layer MLP generator (N_IN -> N_HID -> N_OUT).
// One shared signed fixed-point MAC, one product per clock. Hidden layer uses
// ReLU, output layer uses hard tanh clamped to [-1.0, +1.0].
// Optional feature macro: GENERATOR_SAT_EN -- when defined, the shifted
// product and the accumulator sum saturate instead of wrapping.
module generator_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int N_IN  = 2,
  parameter int N_HID = 3,
  parameter int N_OUT = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  generator_if.slave                   bus,
  input  logic [N_IN*N_HID*WIDTH-1:0]  w_L2,
  input  logic [N_HID*WIDTH-1:0]       b_L2,
  input  logic [N_HID*N_OUT*WIDTH-1:0] w_L3,
  input  logic [N_OUT*WIDTH-1:0]       b_L3
);

  localparam int CW = 16;
  localparam logic [CW-1:0] IN_LAST  = CW'(N_IN - 1);
  localparam logic [CW-1:0] HID_LAST = CW'(N_HID - 1);
  localparam logic [CW-1:0] OUT_LAST = CW'(N_OUT - 1);

  localparam logic signed [WIDTH-1:0] POS_ONE = WIDTH'(1) << FRAC;
  localparam logic signed [WIDTH-1:0] NEG_ONE = -POS_ONE;
  localparam logic signed [WIDTH-1:0] MAX_W   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_W   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [2*WIDTH-1:0] MAX_WIDE = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] MIN_WIDE = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, L2, L3, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           col;   // input index within the current neuron
  logic [CW-1:0]           row;   // neuron index within the current layer
  logic [CW-1:0]           wi;    // linear weight index, equals row*fan_in + col
  logic signed [WIDTH-1:0] acc;
  logic signed [WIDTH-1:0] xr [N_IN];
  logic signed [WIDTH-1:0] h  [N_HID];
  logic signed [WIDTH-1:0] yr [N_OUT];
  logic                    in_ready_r;
  logic                    out_valid_r;

  logic signed [WIDTH-1:0]   op_a;
  logic signed [WIDTH-1:0]   op_b;
  logic signed [WIDTH-1:0]   nb;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] prod_sh;
  logic signed [WIDTH-1:0]   term;
  logic signed [WIDTH-1:0]   acc_next;

  // Reduce a double-width value to WIDTH: truncate, or saturate when enabled.
  function automatic logic signed [WIDTH-1:0] fit_w(input logic signed [2*WIDTH-1:0] v);
    logic signed [WIDTH-1:0] r;
    r = v[WIDTH-1:0];
`ifdef GENERATOR_SAT_EN
    if (v > MAX_WIDE)      r = MAX_W;
    else if (v < MIN_WIDE) r = MIN_W;
`endif
    return r;
  endfunction

  function automatic logic signed [WIDTH-1:0] relu(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? '0 : v;
  endfunction

  function automatic logic signed [WIDTH-1:0] hard_tanh(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] r;
    r = v;
    if (v > POS_ONE)      r = POS_ONE;
    else if (v < NEG_ONE) r = NEG_ONE;
    return r;
  endfunction

  // Operand/bias selection and the shared MAC for the current cycle.
  always_comb begin
    op_a = '0;
    op_b = '0;
    nb   = '0;
    if (state == L3) begin
      for (int n = 0; n < N_HID; n++)
        if (col == CW'(n)) op_a = h[n];
      for (int n = 0; n < N_HID*N_OUT; n++)
        if (wi == CW'(n)) op_b = $signed(w_L3[n*WIDTH +: WIDTH]);
      for (int n = 0; n < N_OUT; n++)
        if (row + CW'(1) == CW'(n)) nb = $signed(b_L3[n*WIDTH +: WIDTH]);
    end else begin
      for (int n = 0; n < N_IN; n++)
        if (col == CW'(n)) op_a = xr[n];
      for (int n = 0; n < N_IN*N_HID; n++)
        if (wi == CW'(n)) op_b = $signed(w_L2[n*WIDTH +: WIDTH]);
      if (row == HID_LAST) begin
        nb = $signed(b_L3[WIDTH-1:0]);
      end else begin
        for (int n = 0; n < N_HID; n++)
          if (row + CW'(1) == CW'(n)) nb = $signed(b_L2[n*WIDTH +: WIDTH]);
      end
    end
    prod     = op_a * op_b;
    prod_sh  = prod >>> FRAC;
    term     = fit_w(prod_sh);
    acc_next = fit_w({{WIDTH{acc[WIDTH-1]}}, acc} + {{WIDTH{term[WIDTH-1]}}, term});
  end

  // Sequencer: accept, hidden layer, output layer, hold result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      acc         <= '0;
      col         <= '0;
      row         <= '0;
      wi          <= '0;
      for (int n = 0; n < N_IN;  n++) xr[n] <= '0;
      for (int n = 0; n < N_HID; n++) h[n]  <= '0;
      for (int n = 0; n < N_OUT; n++) yr[n] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            for (int n = 0; n < N_IN; n++) xr[n] <= $signed(bus.x[n*WIDTH +: WIDTH]);
            acc        <= $signed(b_L2[WIDTH-1:0]);
            col        <= '0;
            row        <= '0;
            wi         <= '0;
            in_ready_r <= 1'b0;
            state      <= L2;
          end
        end
        L2: begin
          wi <= wi + CW'(1);
          if (col == IN_LAST) begin
            for (int n = 0; n < N_HID; n++)
              if (row == CW'(n)) h[n] <= relu(acc_next);
            acc <= nb;
            col <= '0;
            if (row == HID_LAST) begin
              row   <= '0;
              wi    <= '0;
              state <= L3;
            end else begin
              row <= row + CW'(1);
            end
          end else begin
            acc <= acc_next;
            col <= col + CW'(1);
          end
        end
        L3: begin
          wi <= wi + CW'(1);
          if (col == HID_LAST) begin
            for (int n = 0; n < N_OUT; n++)
              if (row == CW'(n)) yr[n] <= hard_tanh(acc_next);
            acc <= nb;
            col <= '0;
            if (row == OUT_LAST) begin
              row         <= '0;
              wi          <= '0;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end else begin
              row <= row + CW'(1);
            end
          end else begin
            acc <= acc_next;
            col <= col + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;

  for (genvar g = 0; g < N_OUT; g++) begin : g_y
    assign bus.y[g*WIDTH +: WIDTH] = yr[g];
  end

endmodule

// File: tb/tb_generator_seq.sv
// Bench for generator_seq: directed scenarios plus randomized vectors checked
// against an arithmetic model of the MLP. Honours GENERATOR_SAT_EN.
module tb_generator_seq;
  localparam int W    = 32;
  localparam int FRAC = 16;
  localparam int NI   = 2;
  localparam int NH   = 3;
  localparam int NO   = 9;

  logic clk = 1'b0;
  logic rst;
  logic [NI*NH*W-1:0] w_L2;
  logic [NH*W-1:0]    b_L2;
  logic [NH*NO*W-1:0] w_L3;
  logic [NO*W-1:0]    b_L3;

  always #5 clk = ~clk;

  generator_if #(.WIDTH(W), .N_IN(NI), .N_OUT(NO)) bus ();

  generator_seq #(.WIDTH(W), .FRAC(FRAC), .N_IN(NI), .N_HID(NH), .N_OUT(NO)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .w_L2 (w_L2),
    .b_L2 (b_L2),
    .w_L3 (w_L3),
    .b_L3 (b_L3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int mx  [NI];
  int mw2 [NI*NH];
  int mb2 [NH];
  int mw3 [NH*NO];
  int mb3 [NO];
  int exp_y [NO];

  task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, req);
    end
  endtask

  function automatic logic signed [31:0] yslice(input int j);
    return bus.y[j*W +: W];
  endfunction

  // Word-size reduction: two's-complement wrap, or clip when saturation is built in.
  function automatic int fit(input longint v);
`ifdef GENERATOR_SAT_EN
    if (v > 64'sd2147483647)  return 32'sh7fffffff;
    if (v < -64'sd2147483648) return 32'sh80000000;
`endif
    return int'(v);
  endfunction

  function automatic int mac(input int acc, input int a, input int b);
    longint p;
    p = (longint'(a) * longint'(b)) >>> FRAC;
    return fit(longint'(acc) + longint'(fit(p)));
  endfunction

  // Reference: evaluate both layers neuron by neuron in plain arithmetic.
  task automatic compute_model();
    int hid [NH];
    int acc;
    for (int i = 0; i < NH; i++) begin
      acc = mb2[i];
      for (int k = 0; k < NI; k++) acc = mac(acc, mx[k], mw2[NI*i+k]);
      hid[i] = (acc < 0) ? 0 : acc;
    end
    for (int j = 0; j < NO; j++) begin
      acc = mb3[j];
      for (int i = 0; i < NH; i++) acc = mac(acc, hid[i], mw3[NH*j+i]);
      if (acc > 65536)       exp_y[j] = 65536;
      else if (acc < -65536) exp_y[j] = -65536;
      else                   exp_y[j] = acc;
    end
  endtask

  task automatic load_buses();
    for (int n = 0; n < NI; n++)    bus.x[n*W +: W] = mx[n];
    for (int n = 0; n < NI*NH; n++) w_L2[n*W +: W]  = mw2[n];
    for (int n = 0; n < NH; n++)    b_L2[n*W +: W]  = mb2[n];
    for (int n = 0; n < NH*NO; n++) w_L3[n*W +: W]  = mw3[n];
    for (int n = 0; n < NO; n++)    b_L3[n*W +: W]  = mb3[n];
  endtask

  task automatic accept(input string name);
    int cnt;
    cnt = 0;
    while (!bus.in_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check({name, " in_ready_idle"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({name, " in_ready_busy"}, bus.in_ready, 0);
  endtask

  // One full transaction; kidx >= 0 adds a fixed-constant check on that slice.
  task automatic run_txn(input string name, input int hold, input int kidx, input int kval);
    int  cnt;
    bit  got;
    compute_model();
    load_buses();
    accept(name);
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 200) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      got = bus.out_valid;
    end
    check({name, " latency"}, cnt, 33);
    for (int j = 0; j < NO; j++) check($sformatf("%s y[%0d]", name, j), yslice(j), exp_y[j]);
    if (kidx >= 0) check($sformatf("%s const y[%0d]", name, kidx), yslice(kidx), kval);
    for (int c = 0; c < hold; c++) begin
      bus.in_valid  = c[0];
      bus.out_ready = 1'b0;
      @(negedge clk);
      check({name, " hold out_valid"}, bus.out_valid, 1);
      check({name, " hold in_ready"}, bus.in_ready, 0);
    end
    if (hold > 0)
      for (int j = 0; j < NO; j++) check($sformatf("%s held y[%0d]", name, j), yslice(j), exp_y[j]);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, " release out_valid"}, bus.out_valid, 0);
    check({name, " release in_ready"}, bus.in_ready, 1);
  endtask

  task automatic set_scn2(input int w3val);
    mx[0] = 32'h00010000;
    mx[1] = 32'h00010000;
    foreach (mw2[n]) mw2[n] = 32'h00010000;
    foreach (mb2[n]) mb2[n] = 0;
    foreach (mw3[n]) mw3[n] = w3val;
    foreach (mb3[n]) mb3[n] = 0;
  endtask

  function automatic int rnd_val(input bit wide);
    if (wide) return int'($urandom);
    return int'($urandom_range(32'h40000, 0)) - 32'h20000;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x         = '0;
    w_L2 = '0; b_L2 = '0; w_L3 = '0; b_L3 = '0;
    repeat (2) @(negedge clk);
    check("reset out_valid", bus.out_valid, 0);
    check("reset in_ready", bus.in_ready, 1);
    check("reset y zero", |bus.y, 0);
    rst = 1'b0;
    @(negedge clk);

    // Zero weights: result is the output bias alone.
    foreach (mx[n])  mx[n]  = rnd_val(1'b0);
    foreach (mw2[n]) mw2[n] = 0;
    foreach (mb2[n]) mb2[n] = rnd_val(1'b0);
    foreach (mw3[n]) mw3[n] = 0;
    foreach (mb3[n]) mb3[n] = 32'h00008000;
    run_txn("bias_only", 0, 4, 32'h00008000);

    set_scn2(32'h00004000);
    run_txn("clip_pos", 0, 0, 32'h00010000);
    set_scn2(32'hFFFFC000);
    run_txn("clip_neg", 0, 8, 32'hFFFF0000);

    // Negative hidden sums are zeroed, leaving only the output biases.
    mx[0] = 32'h00010000;
    mx[1] = 32'h00010000;
    foreach (mw2[n]) mw2[n] = 32'hFFFF0000;
    foreach (mb2[n]) mb2[n] = 0;
    foreach (mw3[n]) mw3[n] = rnd_val(1'b0);
    foreach (mb3[n]) mb3[n] = n * 32'h1000;
    run_txn("relu", 0, 5, 32'h00005000);

    set_scn2(32'h00004000);
    run_txn("hold", 10, 3, 32'h00010000);

    // Reset in the middle of the output layer, then a clean transaction.
    set_scn2(32'h00004000);
    compute_model();
    load_buses();
    accept("abort");
    repeat (20) @(negedge clk);
    check("abort y[0] before reset", yslice(0), 32'h00010000);
    rst = 1'b1;
    #1;
    check("abort out_valid", bus.out_valid, 0);
    check("abort in_ready", bus.in_ready, 1);
    check("abort y zero", |bus.y, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn("after_abort", 0, 2, 32'h00010000);

    // Overflowing products: wrap to zero, or saturate and clip to +1.0.
    mx[0] = 32'h40000000;
    mx[1] = 32'h40000000;
    foreach (mw2[n]) mw2[n] = 32'h00040000;
    foreach (mb2[n]) mb2[n] = 0;
    foreach (mw3[n]) mw3[n] = 0;
    mw3[0] = 32'h00010000;
    foreach (mb3[n]) mb3[n] = 0;
`ifdef GENERATOR_SAT_EN
    run_txn("overflow", 0, 0, 32'h00010000);
`else
    run_txn("overflow", 0, 0, 32'h00000000);
`endif

    for (int t = 0; t < 20; t++) begin
      foreach (mx[n])  mx[n]  = rnd_val(t[0]);
      foreach (mw2[n]) mw2[n] = rnd_val(t[0]);
      foreach (mb2[n]) mb2[n] = rnd_val(1'b0);
      foreach (mw3[n]) mw3[n] = rnd_val(t[0]);
      foreach (mb3[n]) mb3[n] = rnd_val(1'b0);
      run_txn($sformatf("rand%0d", t), int'($urandom_range(3, 0)), -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
